// File: rtl/gate8_arbiter.sv
// Round-robin arbiter sharing one 8-bit bitwise gate unit among N_REQ requesters.
// Optional GATE8_ARB_ERR_EN adds rsp_err, flagging illegal opcodes 6/7 alongside the response.
module gate8_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [3*N_REQ-1:0] req_op,
  input  logic [8*N_REQ-1:0] req_e1,
  input  logic [8*N_REQ-1:0] req_e2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_s,
  output logic               busy
`ifdef GATE8_ARB_ERR_EN
  ,
  output logic               rsp_err
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a request; grant is combinational from the round-robin scan
  // S_EXEC | one cycle evaluating the captured operands into the response register
  // S_RESP | response held until rsp_ready completes the handshake
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, id_q, gnt_id, scan_idx;
  logic            gnt_found;
  logic [2:0]      op_q, sel_op;
  logic [7:0]      e1_q, e2_q, sel_e1, sel_e2, rsp_s_q;
  logic            rsp_valid_q;
  logic            rsp_hs;

  function automatic logic [7:0] gate_eval(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Scan upward from ptr+1 with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_e1 = '0;
    sel_e2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        sel_op = req_op[3*i +: 3];
        sel_e1 = req_e1[8*i +: 8];
        sel_e2 = req_e2[8*i +: 8];
      end
    end
  end

  assign rsp_hs = (state_q == S_RESP) && rsp_valid_q && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_IDLE && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      rsp_s_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && gnt_found) begin
        op_q <= sel_op;
        e1_q <= sel_e1;
        e2_q <= sel_e2;
        id_q <= gnt_id;
      end
      if (state_q == S_EXEC) begin
        rsp_s_q     <= gate_eval(op_q, e1_q, e2_q);
        rsp_valid_q <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
        ptr_q       <= id_q;
      end
    end
  end

`ifdef GATE8_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_q <= 1'b0;
    else if (state_q == S_EXEC)  err_q <= (op_q[2:1] == 2'b11);
    else if (rsp_hs)             err_q <= 1'b0;
  end
  assign rsp_err = err_q;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_gate8_arbiter.sv
// Randomized bench for gate8_arbiter against a transaction-level round-robin/gate model.
// Build with GATE8_ARB_ERR_EN defined to also check rsp_err.
module tb_gate8_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int OPW = 3 * N;
  localparam int DW  = 8 * N;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [OPW-1:0] req_op;
  logic [DW-1:0]  req_e1, req_e2;
  logic           rsp_valid, rsp_ready, busy;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_s;
`ifdef GATE8_ARB_ERR_EN
  logic           rsp_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m_ptr;

  gate8_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_e1(req_e1), .req_e2(req_e2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .busy(busy)
`ifdef GATE8_ARB_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] gate_ref(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return ~a;
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return ~(a & b);
      5: return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    req_valid = N'($urandom);
    req_op    = OPW'($urandom);
    req_e1    = DW'($urandom);
    req_e2    = DW'($urandom);
    rsp_ready = 1'($urandom);
  endtask

  // One full transaction from grant cycle to handshake; operands must already be on the buses.
  task automatic run_txn(input logic [N-1:0] vmask, input int exp_g, input logic [7:0] exp_s,
                         input int hold, output int g_cyc);
    int op_g;
    req_valid = vmask;
    rsp_ready = 1'($urandom);
    op_g = int'(req_op[3*exp_g +: 3]);
    #1;
    chk("grant_ready", 32'(req_ready), 32'(1 << exp_g));
    chk("idle_busy", 32'(busy), 0);
    g_cyc = cyc;
    tick();
    scramble();
    #1;
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_valid", 32'(rsp_valid), 0);
    tick();
    req_valid = N'($urandom);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_s", 32'(rsp_s), 32'(exp_s));
    chk("rsp_id", 32'(rsp_id), 32'(exp_g));
    chk("resp_ready", 32'(req_ready), 0);
`ifdef GATE8_ARB_ERR_EN
    chk("rsp_err", 32'(rsp_err), 32'(op_g >= 6));
`endif
    for (int h = 0; h < hold; h++) begin
      req_valid = N'($urandom);
      tick();
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_s", 32'(rsp_s), 32'(exp_s));
      chk("hold_id", 32'(rsp_id), 32'(exp_g));
      chk("hold_busy", 32'(busy), 1);
      chk("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    m_ptr = exp_g;
  endtask

  task automatic rand_txn(input logic [N-1:0] vmask, input int hold);
    int g, gc;
    req_op = OPW'($urandom);
    req_e1 = DW'($urandom);
    req_e2 = DW'($urandom);
    g = rr_pick(vmask, m_ptr);
    run_txn(vmask, g, gate_ref(int'(req_op[3*g +: 3]), req_e1[8*g +: 8], req_e2[8*g +: 8]), hold, gc);
  endtask

  initial begin
    logic [7:0] sweep_exp [6];
    int gc, prev_gc, g;
    logic [N-1:0] vm;
    sweep_exp = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50};

    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_e1 = '0; req_e2 = '0; rsp_ready = 1'b0;
    m_ptr = N - 1;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_s", 32'(rsp_s), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // req0 AND F0 & 3C
    req_op = '0; req_e1 = '0; req_e2 = '0;
    req_op[2:0] = 3'd1; req_e1[7:0] = 8'hF0; req_e2[7:0] = 8'h3C;
    run_txn(4'b0001, 0, 8'h30, 0, gc);

    // all valid continuously: 1,2,3,0,1 after ptr=0, 3-cycle spacing
    prev_gc = -1;
    for (int t = 0; t < 5; t++) begin
      req_op = OPW'($urandom); req_e1 = DW'($urandom); req_e2 = DW'($urandom);
      g = (t + 1) % N;
      run_txn('1, g, gate_ref(int'(req_op[3*g +: 3]), req_e1[8*g +: 8], req_e2[8*g +: 8]), 0, gc);
      if (prev_gc >= 0) chk("rr_spacing", 32'(gc - prev_gc), 3);
      prev_gc = gc;
    end

    // opcode sweep with fixed operands
    for (int op = 0; op < 6; op++) begin
      for (int i = 0; i < N; i++) begin
        req_op[3*i +: 3] = 3'(op);
        req_e1[8*i +: 8] = 8'hA5;
        req_e2[8*i +: 8] = 8'h0F;
      end
      vm = N'($urandom_range(1, (1 << N) - 1));
      run_txn(vm, rr_pick(vm, m_ptr), sweep_exp[op], 0, gc);
    end

    // long backpressure
    rand_txn(4'b1010, 10);

    // illegal opcode from req2
    req_op = '0; req_e1 = DW'($urandom); req_e2 = DW'($urandom);
    req_op[8:6] = 3'd7;
    run_txn(4'b0100, 2, 8'h00, 1, gc);

    // idle cycles with nothing valid
    req_valid = '0;
    #1;
    chk("idle_ready", 32'(req_ready), 0);
    tick();
    chk("idle_stay", 32'(busy), 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      vm = N'($urandom);
      if (vm == '0) begin
        req_valid = '0;
        rsp_ready = 1'($urandom);
        #1;
        chk("rand_idle_ready", 32'(req_ready), 0);
        tick();
        chk("rand_idle_busy", 32'(busy), 0);
      end else begin
        rand_txn(vm, $urandom_range(0, 3));
      end
    end

    // reset during RESP
    req_op = OPW'($urandom); req_e1 = DW'($urandom); req_e2 = DW'($urandom);
    req_valid = '1;
    tick();
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_s", 32'(rsp_s), 0);
    chk("midrst_id", 32'(rsp_id), 0);
    tick();
    rst_n = 1'b1;
    m_ptr = N - 1;
    tick();
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    rand_txn('1, 0);
    chk("post_rst_ptr", 32'(m_ptr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gate8_arbiter.md
Name: gate8_arbiter

Overview:
Shares one 8-bit bitwise logic unit (NOT/AND/OR/XOR/NAND/NOR) among N_REQ requesters. Round-robin arbitration, valid/ready handshake on each request port, registered operand capture, one execute cycle, and a held response with requester ID. It sits between multiple control sources and the shared 8-bit gate datapath.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
ID_W, 2, width of requester ID; must equal clog2(N_REQ).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  N_REQ  request pending, one bit per requester.
req_ready  output  N_REQ  grant/accept, one-hot or zero.
req_op  input  3*N_REQ  opcode per requester; requester i uses bits [3i+2:3i].
req_e1  input  8*N_REQ  operand 1 per requester; requester i uses bits [8i+7:8i].
req_e2  input  8*N_REQ  operand 2 per requester; ignored for NOT.
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumer accepts.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_s  output  8  result.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Opcodes: 0 NOT e1; 1 AND; 2 OR; 3 XOR; 4 NAND; 5 NOR; 6 and 7 illegal, result 8'h00. All operations are bitwise per bit.
- FSM states are IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: when any req_valid is high, grant the first valid requester scanning upward from ptr+1, wrapping modulo N_REQ.
  - req_ready[grant] is high combinationally in the same cycle. No other ready is high.
  - On that edge, capture op, e1, e2 and grant ID, then go to EXEC.
  - When no req_valid is high, req_ready is 0 and the FSM stays in IDLE.
- EXEC: compute the result from the captured operands into the rsp_s register, set rsp_valid, then go to RESP. Lasts exactly 1 cycle.
- RESP: rsp_valid, rsp_s and rsp_id are held stable until rsp_ready is high.
  - On the edge where rsp_valid and rsp_ready are both high: clear rsp_valid, set ptr to the grant ID, return to IDLE.
- req_ready is 0 in EXEC and RESP. There is no overlap of requests.
- Latency: request accepted at edge T gives rsp_valid high after edge T+1, visible in cycle T+1..T+2. Minimum throughput is 1 op per 3 cycles when rsp_ready is held high.
- ptr reset value is N_REQ-1, so requester 0 has first priority after reset.
- A requester dropping req_valid before it is granted is legal and has no effect. Once captured, the operation completes regardless of later req_valid or operand changes.
- Reset values: req_ready=0, rsp_valid=0, rsp_s=8'h00, rsp_id=0, busy=0, internal operand registers 0.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation immediately. The response is lost and no stale rsp_valid appears after release.
- If rsp_ready is high while rsp_valid is low, it is ignored.

Optional Feature:
Macro GATE8_ARB_ERR_EN.
- Defined: adds output port rsp_err (1 bit). It is set in EXEC when the captured opcode is 6 or 7, held with rsp_valid, and cleared on response handshake and on reset.
- Not defined: no rsp_err port. Illegal opcodes silently return 8'h00 with normal timing.

Test Plan:
- Reset, then req0 only with op=1, e1=8'hF0, e2=8'h3C. Expect req_ready=4'b0001 in the request cycle, rsp_valid after 2 edges, rsp_s=8'h30, rsp_id=0.
- All 4 requesters valid continuously, rsp_ready=1. Expect grants in order 0,1,2,3,0. Each ready is one-hot, and one response occurs every 3 cycles.
- Sweep op=0..5 with e1=8'hA5, e2=8'h0F. Expect 5A, 05, AF, AA, FA, 50 respectively.
- Hold rsp_ready=0 for 10 cycles after response. Expect rsp_valid, rsp_s and rsp_id stable, busy=1, all req_ready=0. Release: one handshake, then IDLE.
- op=7 from req2. Expect rsp_s=8'h00, rsp_id=2, and rsp_err=1 only when GATE8_ARB_ERR_EN is defined.
- Assert rst_n low during RESP. Expect rsp_valid=0 immediately, and after release the next grant goes to req0.
